// File: rtl/pwm_pkg.sv
// pwm_pkg: shared state type and sizing constants for the PWM generator.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } pwm_state_e;

    localparam int PWM_WIDTH_DEF = 8;
    localparam int DT_CNT_W      = 4;

endpackage

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: complementary output pair with a blanking gap after every compare change.
// Only compiled when PWM_DEADTIME_EN is defined.
`ifdef PWM_DEADTIME_EN
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int DT_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_cmp,
    output logic o_pwm,
    output logic o_pwm_n
);

    localparam logic [DT_CNT_W-1:0] DT_LOAD = DT_CNT_W'(DT_CYCLES);

    logic [1:0]          r_prev;
    logic [DT_CNT_W-1:0] r_dt_cnt;
    logic                r_pwm;
    logic                r_pwm_n;
    logic                w_changed;

    // Enable is part of the change detect so a fresh start also gets a gap.
    assign w_changed = ({i_en, i_cmp} != r_prev);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev   <= 2'b00;
            r_dt_cnt <= '0;
            r_pwm    <= 1'b0;
            r_pwm_n  <= 1'b0;
        end else begin
            r_prev <= {i_en, i_cmp};
            if (w_changed) begin
                r_dt_cnt <= DT_LOAD;
                r_pwm    <= 1'b0;
                r_pwm_n  <= 1'b0;
            end else if (r_dt_cnt > DT_CNT_W'(1)) begin
                r_dt_cnt <= r_dt_cnt - 1'b1;
                r_pwm    <= 1'b0;
                r_pwm_n  <= 1'b0;
            end else begin
                r_dt_cnt <= '0;
                r_pwm    <= i_en & i_cmp;
                r_pwm_n  <= i_en & ~i_cmp;
            end
        end
    end

    assign o_pwm   = r_pwm;
    assign o_pwm_n = r_pwm_n;

endmodule
`endif

// File: rtl/pwm_gen.sv
// pwm_gen: edge-aligned PWM following an external wrap counter, double-buffered duty.
// Define PWM_DEADTIME_EN for the complementary output with dead-time (pwm_deadtime).
//
// state | meaning
// IDLE  | outputs low, waiting for pwm_en
// ARM   | enabled, waiting for the next wrap so the first period is whole
// RUN   | generating PWM
// DRAIN | pwm_en dropped, finishing the current period
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int WIDTH     = PWM_WIDTH_DEF,
    parameter int DT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_en,
    input  logic [WIDTH-1:0] count,
    input  logic             carry,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    input  logic             pwm_en,
    output logic             pwm_out,
    output logic             pwm_n,
    output logic             period_done,
    output logic [WIDTH-1:0] duty_active,
    output logic             running
);

    if (DT_CYCLES < 1 || DT_CYCLES > 15) begin : g_dt_range
        $error("pwm_gen: DT_CYCLES must be in 1..15");
    end

    pwm_state_e       r_state;
    logic             r_running;
    logic             r_period_done;
    logic [WIDTH-1:0] r_duty_active;
    logic [WIDTH-1:0] r_pend_duty;
    logic             r_pend_full;
    logic             w_bnd;
    logic             w_load;
    logic             w_cmp;

    assign w_bnd  = carry & cnt_en;
    assign w_load = duty_valid & ~r_pend_full;
    assign w_cmp  = r_running & (count < r_duty_active);

    // A load coinciding with a wrap lands in pending and waits one more period.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_duty_active <= '0;
            r_pend_duty   <= '0;
            r_pend_full   <= 1'b0;
        end else if (w_bnd && r_pend_full) begin
            r_duty_active <= r_pend_duty;
            r_pend_full   <= 1'b0;
        end else if (w_load) begin
            r_pend_duty   <= duty_in;
            r_pend_full   <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_running     <= 1'b0;
            r_period_done <= 1'b0;
        end else begin
            r_period_done <= w_bnd & r_running;
            case (r_state)
                IDLE: begin
                    if (pwm_en) r_state <= ARM;
                end
                ARM: begin
                    if (!pwm_en) begin
                        r_state <= IDLE;
                    end else if (w_bnd) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                    end
                end
                RUN: begin
                    if (!pwm_en) r_state <= DRAIN;
                end
                DRAIN: begin
                    if (pwm_en) begin
                        r_state <= RUN;
                    end else if (w_bnd) begin
                        r_state   <= IDLE;
                        r_running <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

`ifdef PWM_DEADTIME_EN
    pwm_deadtime #(
        .DT_CYCLES (DT_CYCLES)
    ) u_deadtime (
        .clk     (clk),
        .rst     (rst),
        .i_en    (r_running),
        .i_cmp   (w_cmp),
        .o_pwm   (pwm_out),
        .o_pwm_n (pwm_n)
    );
`else
    logic r_pwm_out;

    always_ff @(posedge clk) begin
        if (rst) r_pwm_out <= 1'b0;
        else     r_pwm_out <= w_cmp;
    end

    assign pwm_out = r_pwm_out;
    assign pwm_n   = 1'b0;
`endif

    assign duty_ready  = ~r_pend_full;
    assign duty_active = r_duty_active;
    assign period_done = r_period_done;
    assign running     = r_running;

endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: directed corner sequences, a duty table and a randomized run of pwm_gen,
// checked every cycle against a queue-based behavioural model (PWM_DEADTIME_EN aware).
`timescale 1ns/1ps
module tb_pwm_gen;

    localparam int W      = 8;
    localparam int DT     = 2;
    localparam int PERIOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         cnt_en;
    logic [W-1:0] count;
    logic         carry;
    logic [W-1:0] duty_in;
    logic         duty_valid;
    logic         duty_ready;
    logic         pwm_en;
    logic         pwm_out;
    logic         pwm_n;
    logic         period_done;
    logic [W-1:0] duty_active;
    logic         running;

    int checks = 0;
    int errors = 0;

    pwm_gen #(
        .WIDTH     (W),
        .DT_CYCLES (DT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cnt_en      (cnt_en),
        .count       (count),
        .carry       (carry),
        .duty_in     (duty_in),
        .duty_valid  (duty_valid),
        .duty_ready  (duty_ready),
        .pwm_en      (pwm_en),
        .pwm_out     (pwm_out),
        .pwm_n       (pwm_n),
        .period_done (period_done),
        .duty_active (duty_active),
        .running     (running)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Behavioural model: active duty, a one-deep pending queue, and a run/arm/drain view.
    int  m_act;
    int  m_pend[$];
    bit  m_running, m_armed, m_draining, m_was_run;
    bit  m_pwm, m_pd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        bit bnd, ready;
        bnd       = carry && cnt_en;
        m_was_run = m_running;
        if (rst) begin
            m_act = 0;
            m_pend.delete();
            m_running  = 0;
            m_armed    = 0;
            m_draining = 0;
            m_was_run  = 0;
            m_pwm      = 0;
            m_pd       = 0;
            return;
        end
        m_pwm = m_was_run && (int'(count) < m_act);
        m_pd  = m_was_run && bnd;
        ready = (m_pend.size() == 0);
        if (bnd && !ready) m_act = m_pend.pop_front();
        if (duty_valid && ready) m_pend.push_back(int'(duty_in));
        if (!m_was_run) begin
            if (!m_armed)     m_armed = pwm_en;
            else if (!pwm_en) m_armed = 0;
            else if (bnd) begin
                m_running = 1;
                m_armed   = 0;
            end
        end else if (m_draining && !pwm_en && bnd) begin
            m_running = 0;
        end
        m_draining = m_running && !pwm_en;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        if (cnt_en) count = count + 1'b1;
        carry = (count == {W{1'b1}});
        chk("period_done", period_done, m_pd);
        chk("duty_active", duty_active, m_act);
        chk("duty_ready", duty_ready, m_pend.size() == 0);
        chk("running", running, m_running);
`ifdef PWM_DEADTIME_EN
        chk("no_overlap", pwm_out & pwm_n, 0);
        if (!m_was_run) chk("idle_outputs_low", {pwm_out, pwm_n}, 0);
`else
        chk("pwm_out", pwm_out, m_pwm);
        chk("pwm_n", pwm_n, 0);
`endif
    endtask

    task automatic wait_running(input string name, input int limit);
        int n = 0;
        while (!running && n < limit) begin tick(); n++; end
        chk(name, running, 1);
    endtask

    task automatic wait_count(input string name, input logic [W-1:0] v, input int limit);
        int n = 0;
        while (count != v && n < limit) begin tick(); n++; end
        chk(name, count, v);
    endtask

    task automatic wait_active(input string name, input logic [W-1:0] v, input int limit);
        int n = 0;
        while (duty_active != v && n < limit) begin tick(); n++; end
        chk(name, duty_active, v);
    endtask

    task automatic wait_pd(input string name, input int limit);
        int n = 0;
        do begin tick(); n++; end while (!period_done && n < limit);
        chk(name, period_done, 1);
    endtask

    task automatic load_duty(input logic [W-1:0] d);
        int n = 0;
        while (!duty_ready && n < 1000) begin tick(); n++; end
        chk("load_ready", duty_ready, 1);
        duty_in    = d;
        duty_valid = 1'b1;
        tick();
        duty_valid = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0] duty;
        int           exp_high;
        int           exp_both_low;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int hi, bl, pd, bad;

`ifdef PWM_DEADTIME_EN
        tbl[0] = '{8'd0,   0,        0};
        tbl[1] = '{8'd1,   0,        DT + 1};
        tbl[2] = '{8'd64,  64 - DT,  2 * DT};
        tbl[3] = '{8'd128, 128 - DT, 2 * DT};
        tbl[4] = '{8'd200, 200 - DT, 2 * DT};
        tbl[5] = '{8'd255, 255 - DT, DT + 1};
`else
        tbl[0] = '{8'd0,   0,   256};
        tbl[1] = '{8'd1,   1,   255};
        tbl[2] = '{8'd64,  64,  192};
        tbl[3] = '{8'd128, 128, 128};
        tbl[4] = '{8'd200, 200, 56};
        tbl[5] = '{8'd255, 255, 1};
`endif

        rst        = 1'b1;
        cnt_en     = 1'b0;
        count      = '0;
        carry      = 1'b0;
        duty_in    = '0;
        duty_valid = 1'b0;
        pwm_en     = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_pwm_out", pwm_out, 0);
        chk("rst_pwm_n", pwm_n, 0);
        chk("rst_duty_active", duty_active, 0);
        chk("rst_duty_ready", duty_ready, 1);
        chk("rst_running", running, 0);
        chk("rst_period_done", period_done, 0);
        rst    = 1'b0;
        cnt_en = 1'b1;

        // Duty 64 from a cold start: RUN after first wrap, 64 high clocks per period
        pwm_en = 1'b1;
        load_duty(8'd64);
        wait_running("t2_run", 600);
        chk("t2_duty_active", duty_active, 64);
        hi = 0; pd = 0;
        for (int i = 0; i < PERIOD; i++) begin
            tick();
            hi += int'(pwm_out);
            pd += int'(period_done);
        end
`ifdef PWM_DEADTIME_EN
        chk("t2_high_clocks", hi, 64 - DT);
`else
        chk("t2_high_clocks", hi, 64);
`endif
        chk("t2_period_done_count", pd, 1);

        // Mid-period load only takes effect at the wrap
        wait_count("t3_reach_100", 8'd100, 600);
        load_duty(8'd200);
        chk("t3_ready_low", duty_ready, 0);
        chk("t3_active_old", duty_active, 64);
        wait_pd("t3_wrap", 400);
        chk("t3_active_new", duty_active, 200);
        chk("t3_ready_high", duty_ready, 1);

        // Handshake on the wrap cycle goes to pending, not active
        wait_count("t3b_reach_255", 8'd255, 600);
        load_duty(8'd33);
        chk("t3b_active_kept", duty_active, 200);
        chk("t3b_pending_full", duty_ready, 0);
        wait_pd("t3b_next_wrap", 400);
        chk("t3b_active_next", duty_active, 33);

        // Drain to idle, then re-raise during drain
        wait_count("t4_reach_100", 8'd100, 600);
        pwm_en = 1'b0;
        wait_pd("t4_drain_wrap", 400);
        chk("t4_idle_after_drain", running, 0);
        tick();
        tick();
        chk("t4_out_low_idle", pwm_out, 0);
        pwm_en = 1'b1;
        wait_running("t4_rearm", 600);
        wait_count("t4_reach_100b", 8'd100, 600);
        pwm_en = 1'b0;
        wait_count("t4_reach_150", 8'd150, 600);
        chk("t4_drain_running", running, 1);
        pwm_en = 1'b1;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            bad += int'(!running);
        end
        chk("t4_no_gap", bad, 0);

        // Counter hold: level holds, no boundary even with carry high
        load_duty(8'd10);
        wait_active("t5_active", 8'd10, 600);
        wait_count("t5_reach_5", 8'd5, 600);
        cnt_en = 1'b0;
        bad = 0; pd = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            bad += int'(pwm_out !== 1'b1);
            pd  += int'(period_done);
        end
        chk("t5_hold_high", bad, 0);
        chk("t5_hold_no_pd", pd, 0);
        cnt_en = 1'b1;
        wait_count("t5_reach_255", 8'd255, 600);
        cnt_en = 1'b0;
        pd = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            pd += int'(period_done);
        end
        chk("t5_carry_hold_no_pd", pd, 0);
        chk("t5_carry_hold_active", duty_active, 10);
        cnt_en = 1'b1;

        // Reset mid-run with pending full discards everything
        load_duty(8'd77);
        chk("t1_pending_full", duty_ready, 0);
        rst = 1'b1;
        tick();
        chk("t1_pwm_out", pwm_out, 0);
        chk("t1_duty_active", duty_active, 0);
        chk("t1_duty_ready", duty_ready, 1);
        chk("t1_running", running, 0);
        chk("t1_period_done", period_done, 0);
        rst = 1'b0;

        // Duty table: steady-state high and both-low clocks per period
        pwm_en = 1'b1;
        cnt_en = 1'b1;
        wait_running("tbl_run", 600);
        for (int k = 0; k < 6; k++) begin
            load_duty(tbl[k].duty);
            wait_active($sformatf("tbl_active_%0d", tbl[k].duty), tbl[k].duty, 600);
            for (int i = 0; i < 20; i++) tick();
            hi = 0; bl = 0; pd = 0;
            for (int i = 0; i < PERIOD; i++) begin
                tick();
                hi += int'(pwm_out);
                bl += int'(!pwm_out && !pwm_n);
                pd += int'(period_done);
            end
            chk($sformatf("tbl_high_%0d", tbl[k].duty), hi, tbl[k].exp_high);
            chk($sformatf("tbl_both_low_%0d", tbl[k].duty), bl, tbl[k].exp_both_low);
            chk($sformatf("tbl_pd_%0d", tbl[k].duty), pd, 1);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 5000; i++) begin
            cnt_en     = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 399) == 0) pwm_en = ~pwm_en;
            duty_valid = ($urandom_range(0, 49) == 0);
            duty_in    = W'($urandom);
            rst        = ($urandom_range(0, 2999) == 0);
            tick();
        end
        rst        = 1'b0;
        duty_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_gen.md
Name: pwm_gen

Overview:
Downstream consumer of the 8-bit synchronous counter. It takes the counter's `count`, `carry` and `cnt_en` and produces an edge-aligned PWM output whose period is one full counter wrap (2^WIDTH enabled clocks). Duty values arrive over a valid/ready handshake and are double-buffered. The live duty value changes only at a period boundary, so no glitched or partial periods are produced.

Parameters:
- WIDTH, 8, width of count/duty; must match the upstream counter.
- DT_CYCLES, 2, dead-time length in clocks; only meaningful with PWM_DEADTIME_EN; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- cnt_en  input  1  counter enable, the same net that drives the counter.
- count  input  WIDTH  counter value.
- carry  input  1  counter terminal flag; high while count == all-ones.
- duty_in  input  WIDTH  requested duty (high-time in counts).
- duty_valid  input  1  duty_in is valid.
- duty_ready  output  1  pending buffer empty; a transfer occurs when duty_valid & duty_ready.
- pwm_en  input  1  level request to run PWM.
- pwm_out  output  1  PWM output, registered.
- pwm_n  output  1  complementary output (PWM_DEADTIME_EN only).
- period_done  output  1  one-cycle pulse per completed period.
- duty_active  output  WIDTH  duty currently in use.
- running  output  1  high in the RUN and DRAIN states.

Behaviour:
- Reset values: duty_active = 0, pending buffer empty, duty_ready = 1, pwm_out = 0, pwm_n = 0, period_done = 0, running = 0, state = IDLE.
- Reset mid-period: all of the above are restored on the next edge; a pending duty is discarded.
- Boundary event: `bnd = carry & cnt_en`. This is the edge on which the counter wraps to 0.
- Pending buffer:
  - A handshake loads pending and drops duty_ready on the next cycle.
  - At `bnd`, if pending is full, pending moves to duty_active and duty_ready rises on the next cycle.
  - If a handshake and `bnd` occur in the same cycle with pending empty, the new value goes to pending, not to duty_active. It takes effect at the following boundary.
- State machine:
  - IDLE → ARM when pwm_en = 1.
  - ARM → RUN on `bnd`; duty transfer is applied on that same edge.
  - ARM → IDLE if pwm_en drops before `bnd`.
  - RUN → DRAIN when pwm_en = 0.
  - DRAIN → IDLE on `bnd`.
  - DRAIN → RUN if pwm_en returns to 1 before `bnd`.
- Output generation:
  - In RUN/DRAIN: `pwm_out <= (count < duty_active)`, giving 1 cycle of latency relative to count.
  - In IDLE/ARM: pwm_out is held at 0.
  - duty = 0 gives a constant low output.
  - duty = 2^WIDTH−1 gives high for 255 of 256 enabled counts; 100 % duty is not representable.
- count hold: when cnt_en = 0, count holds and pwm_out holds its level; no boundary can occur.
- Compare source: the comparison always uses the post-transfer duty_active.
- period_done: pulses the cycle after a `bnd` edge taken in RUN or DRAIN, including the final DRAIN→IDLE boundary. It does not pulse for ARM→RUN.
- duty_active width: exactly WIDTH bits; no arithmetic overflow is possible.

Optional Feature:
- Macro: PWM_DEADTIME_EN.
- Defined:
  - pwm_n is the complement of the raw compare.
  - After any change of the raw compare, both pwm_out and pwm_n are driven 0 for DT_CYCLES clocks; then the new side asserts.
  - A change during dead-time restarts the dead-time counter.
  - If a pulse is shorter than DT_CYCLES, that side never asserts.
  - In IDLE/ARM both outputs are 0.
  - Total output latency is 1 + DT_CYCLES clocks on the asserting edge.
- Not defined: pwm_n is tied to 0, there is no dead-time counter, and pwm_out behaves as above.

Decomposition:
- Shared package `pwm_pkg`:
  - state enum (IDLE, ARM, RUN, DRAIN);
  - default WIDTH;
  - DT counter width constant (4).
- Sub-module `pwm_deadtime`: takes the raw compare bit and produces pwm_out/pwm_n. It is instantiated only under PWM_DEADTIME_EN.

Test Plan:
1. Apply reset mid-run with pending full → next cycle: pwm_out = 0, duty_active = 0, duty_ready = 1, state IDLE.
2. Handshake duty 64, pwm_en = 1, free-running counter → RUN after the first wrap; pwm_out high for count 0..63 (seen at 1..64 due to latency), 64 high clocks per 256; period_done pulses once per 256 clocks.
3. Load duty 200 mid-period while duty_active = 64 → current period stays at 64 high; next period at 200; duty_ready low until the boundary, then high.
4. Drop pwm_en at count = 100 → pwm_out completes the period, period_done pulses at the wrap, then IDLE with pwm_out = 0. Re-raise pwm_en at count = 150 in DRAIN → stays RUN, no gap.
5. Hold cnt_en low for 20 cycles with duty 10 at count = 5 → pwm_out holds 1; no boundary and no period_done. Duty 0 → constant low; duty 255 → exactly 1 low clock per period.
6. PWM_DEADTIME_EN, DT_CYCLES = 2, duty 64 → pwm_out/pwm_n never both high; exactly 2 both-low clocks at each transition. Duty 1 → pwm_out never asserts.
